serial_frame_tx: RTL and testbench

- Parallel-to-serial framer that sits directly upstream of the single-bit sequence-detector FSM and drives its din input.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Marks the serial stream with bit_valid and frame_done, and drives a defined idle level between words.
- Supports back-to-back words with no gap cycle.

---
 rtl/serial_frame_tx.sv | 78 +++++++
 tb/tb_serial_frame_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framer: takes a WIDTH-bit word over valid/ready and shifts it
// out one bit per clock on dout, with bit_valid/frame_done framing and zero-gap chaining.
module serial_frame_tx #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             dout,
    output logic             bit_valid,
    output logic             frame_done
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   ONE      = CW'(1);
    localparam logic [0:0]      ST_IDLE  = 1'b0;
    localparam logic [0:0]      ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_inc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shreg_step;
    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;

    // count tracks the index of the bit currently on dout, so the last bit
    // is visible exactly when count reaches WIDTH-1.
    always_comb begin
        last_bit   = (state == ST_SHIFT) && (count == LAST);
        ready_out  = !reset && ((state == ST_IDLE) || last_bit);
        accept     = valid_in && ready_out;
        count_inc  = count + ONE;
        first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
        load_rest  = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
        next_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        shreg_step = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            shreg      <= '0;
            dout       <= IDLE_BIT;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else if (accept) begin
            // The first bit goes straight to dout; only the remainder is held.
            state      <= ST_SHIFT;
            count      <= '0;
            shreg      <= load_rest;
            dout       <= first_bit;
            bit_valid  <= 1'b1;
            frame_done <= 1'b0;
        end else if (state == ST_SHIFT && !last_bit) begin
            count      <= count_inc;
            shreg      <= shreg_step;
            dout       <= next_bit;
            frame_done <= (count_inc == LAST);
        end else if (last_bit) begin
            state      <= ST_IDLE;
            count      <= '0;
            dout       <= IDLE_BIT;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a queue-of-bits model of the framed serial stream.
module tb_serial_frame_tx;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_m, dout_m, bv_m, fd_m;
    logic         ready_l, dout_l, bv_l, fd_l;

    int unsigned  vectors;
    int unsigned  miscompares;

    // Model: pending output bits per bit order, plus a last-bit marker per slot.
    bit           qm[$];
    bit           ql[$];
    bit           qlast[$];
    bit           cur_v;
    bit           cur_last;
    bit           cur_bm;
    bit           cur_bl;

    serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_m), .dout(dout_m), .bit_valid(bv_m), .frame_done(fd_m)
    );

    serial_frame_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_l), .dout(dout_l), .bit_valid(bv_l), .frame_done(fd_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge: drive inputs, check ready, take the edge, check outputs.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] d, output bit acc);
        bit exp_rdy;
        reset    = r;
        valid_in = v;
        data_in  = d;
        #1;
        exp_rdy = !r && (!cur_v || cur_last);
        chk("ready_m", ready_m, exp_rdy);
        chk("ready_l", ready_l, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            qm.delete();
            ql.delete();
            qlast.delete();
            cur_v    = 1'b0;
            cur_last = 1'b0;
        end else begin
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(d[W-1-i]);
                    ql.push_back(d[i]);
                    qlast.push_back(i == W - 1);
                end
            end
            if (qm.size() > 0) begin
                cur_v    = 1'b1;
                cur_bm   = qm.pop_front();
                cur_bl   = ql.pop_front();
                cur_last = qlast.pop_front();
            end else begin
                cur_v    = 1'b0;
                cur_last = 1'b0;
            end
        end
        @(negedge clk);
        chk("dout_m", dout_m, cur_v ? cur_bm : 1'b1);
        chk("dout_l", dout_l, cur_v ? cur_bl : 1'b1);
        chk("bit_valid_m", bv_m, cur_v);
        chk("bit_valid_l", bv_l, cur_v);
        chk("frame_done_m", fd_m, cur_v && cur_last);
        chk("frame_done_l", fd_l, cur_v && cur_last);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, acc);
    endtask

    // Hold valid_in with d until the model says it was accepted (bounded).
    task automatic send(input logic [W-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 2 * W + 4 && !acc; i++) cycle(1'b0, 1'b1, d, acc);
        if (!acc) begin
            vectors++;
            miscompares++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted data=%h", d);
        end
    endtask

    initial begin
        bit acc;
        vectors     = 0;
        miscompares = 0;
        cur_v       = 1'b0;
        cur_last    = 1'b0;
        cur_bm      = 1'b0;
        cur_bl      = 1'b0;
        reset       = 1'b1;
        valid_in    = 1'b0;
        data_in     = '0;
        @(negedge clk);

        cycle(1'b1, 1'b0, '0, acc);
        cycle(1'b1, 1'b1, 8'hFF, acc);
        idle(3);

        send(8'hA5);
        idle(10);

        send(8'hA5);
        send(8'h3C);
        idle(10);

        send(8'h00);
        send(8'hFF);
        idle(10);

        send(8'hA5);
        idle(3);
        cycle(1'b1, 1'b0, '0, acc);
        idle(2);
        send(8'h81);
        idle(10);

        send(8'h01);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                  W'($urandom), acc);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
